// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and the LSU.
// One transaction in flight at a time; a streak limit keeps IF from starving behind LSU traffic.
module mem_port_arbiter #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              if_req_v,
  input  logic [AW-1:0]     if_addr,
  output logic              if_rvalid,
  output logic [DW-1:0]     if_rdata,
  output logic              if_stall,
  input  logic              d_req_v,
  input  logic              d_we,
  input  logic [DW/8-1:0]   d_be,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW-1:0]     d_wdata,
  output logic              d_rvalid,
  output logic [DW-1:0]     d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DW/8-1:0]   mem_be,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DW-1:0]     mem_rdata
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state_q, state_d;
  logic              own_lsu_q, own_lsu_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              drop_q, drop_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DW/8-1:0]   mem_be_q, mem_be_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic              if_cand, pick_if, if_rv, d_rv;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      own_lsu_q   <= 1'b0;
      streak_q    <= '0;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      own_lsu_q   <= own_lsu_d;
      streak_q    <= streak_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    own_lsu_d   = own_lsu_q;
    streak_d    = streak_q;
    drop_d      = drop_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rv       = 1'b0;
    d_rv        = 1'b0;
    // A redirecting fetch is not a real request this cycle.
    if_cand     = if_req_v & ~flush;
    pick_if     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_cand || d_req_v) begin
          pick_if   = if_cand & (~d_req_v | (streak_q == SMAX));
          own_lsu_d = ~pick_if;
          state_d   = REQ;
          mem_req_d = 1'b1;
          drop_d    = 1'b0;
          if (pick_if) begin
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            streak_d    = '0;
          end else begin
            mem_we_d    = d_we;
            mem_be_d    = d_be;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (!if_cand)               streak_d = '0;
            else if (streak_q != SMAX)  streak_d = streak_q + 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
        end
        if (!own_lsu_q && flush) drop_d = 1'b1;
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (own_lsu_q) d_rv  = 1'b1;
          else           if_rv = ~drop_q & ~flush;
        end else if (!own_lsu_q && flush) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_rvalid = if_rv & ~reset;
  assign d_rvalid  = d_rv & ~reset;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign if_stall  = if_req_v & ~if_rvalid;
  assign d_stall   = d_req_v & ~d_rvalid;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Responses are only legal once the request has been accepted.
  a_no_rvalid_in_req: assert property (@(posedge clk) disable iff (reset)
    !(state_q == REQ && mem_rvalid));
endmodule
